// File: rtl/uart_rx_poller.sv
// AXI4-Lite read master that polls a UART Lite STAT register, drains RX bytes into a local FIFO
// and presents them as a valid/ready byte stream. Define UART_POLL_RESP_CHK_EN to enable RRESP checking.
//
// state     | meaning
// S_IDLE    | waiting for enable, poll gap expiry and FIFO space
// S_STAT_AR | STAT read address presented, waiting for ARREADY
// S_STAT_R  | waiting for the STAT read beat
// S_RX_AR   | RX FIFO read address presented, waiting for ARREADY
// S_RX_R    | waiting for the RX read beat, byte pushed on arrival
module uart_rx_poller #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          POLL_GAP   = 4,
    parameter logic [31:0] STAT_ADDR  = 32'h8,
    parameter logic [31:0] RX_ADDR    = 32'h0
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          enable,
    output logic [31:0]                   M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
`ifdef UART_POLL_RESP_CHK_EN
    output logic                          resp_err,
`endif
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(POLL_GAP + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STAT_AR,
        S_STAT_R,
        S_RX_AR,
        S_RX_R
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        araddr_nxt;
    logic               arvalid_nxt;
    logic               rready_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               push;
    logic               ar_hs, r_hs, r_ok;
    logic               fifo_full, do_push, pop;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic               unused_bits;

    assign ar_hs        = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs         = M_AXI_RVALID & M_AXI_RREADY;
    assign M_AXI_ARPROT = 3'b000;
    assign busy         = (state != S_IDLE);

`ifdef UART_POLL_RESP_CHK_EN
    assign r_ok        = (M_AXI_RRESP == 2'b00);
    assign unused_bits = ^M_AXI_RDATA[31:8];
`else
    assign r_ok        = 1'b1;
    assign unused_bits = ^{M_AXI_RDATA[31:8], M_AXI_RRESP};
`endif

    always_comb begin
        state_nxt   = state;
        araddr_nxt  = M_AXI_ARADDR;
        arvalid_nxt = M_AXI_ARVALID;
        rready_nxt  = M_AXI_RREADY;
        gap_nxt     = gap_cnt;
        push        = 1'b0;
        case (state)
            S_IDLE: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end else if (enable && !fifo_full) begin
                    araddr_nxt  = STAT_ADDR;
                    arvalid_nxt = 1'b1;
                    state_nxt   = S_STAT_AR;
                end
            end
            S_STAT_AR: begin
                if (ar_hs) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = S_STAT_R;
                end
            end
            S_STAT_R: begin
                if (r_hs) begin
                    rready_nxt = 1'b0;
                    if (r_ok && M_AXI_RDATA[0]) begin
                        araddr_nxt  = RX_ADDR;
                        arvalid_nxt = 1'b1;
                        state_nxt   = S_RX_AR;
                    end else begin
                        gap_nxt   = GAP_W'(POLL_GAP);
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_RX_AR: begin
                if (ar_hs) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = S_RX_R;
                end
            end
            S_RX_R: begin
                if (r_hs) begin
                    rready_nxt = 1'b0;
                    push       = r_ok;
                    gap_nxt    = '0;
                    state_nxt  = S_IDLE;
                end
            end
            default: begin
                arvalid_nxt = 1'b0;
                rready_nxt  = 1'b0;
                state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state         <= S_IDLE;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            gap_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            M_AXI_ARADDR  <= araddr_nxt;
            M_AXI_ARVALID <= arvalid_nxt;
            M_AXI_RREADY  <= rready_nxt;
            gap_cnt       <= gap_nxt;
        end
    end

`ifdef UART_POLL_RESP_CHK_EN
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            resp_err <= 1'b0;
        end else if (r_hs && !r_ok && (state == S_STAT_R || state == S_RX_R)) begin
            resp_err <= 1'b1;
        end
    end
`endif

    // Byte FIFO; the storage is cleared on reset so byte_data reads 0 when empty after reset
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign byte_valid = (fifo_count != '0);
    assign byte_data  = mem[rptr];
    assign pop        = byte_valid & byte_ready;
    assign do_push    = push & ~fifo_full;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= M_AXI_RDATA[7:0];
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (do_push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!do_push && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_poller.sv
// Directed + randomized bench for uart_rx_poller acting as the AXI UART slave and the byte consumer.
// Expected bytes are tracked in a queue; poll timing is derived from POLL_GAP.
module tb_uart_rx_poller;

    localparam int          DEPTH = 8;
    localparam int          GAP   = 4;
    localparam logic [31:0] STAT  = 32'h8;
    localparam logic [31:0] RX    = 32'h0;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [31:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = 2'b00;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        busy;
`ifdef UART_POLL_RESP_CHK_EN
    logic        resp_err;
`endif

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];

    uart_rx_poller #(
        .FIFO_DEPTH(DEPTH), .POLL_GAP(GAP), .STAT_ADDR(STAT), .RX_ADDR(RX)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .enable(enable),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .fifo_count(fifo_count), .overflow(overflow),
`ifdef UART_POLL_RESP_CHK_EN
        .resp_err(resp_err),
`endif
        .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One full AR/R transaction as the slave; rise_c is the cycle ARVALID was first seen
    task automatic serve(input logic [31:0] data, input int ar_stall, input int r_lat,
                         input logic [1:0] resp, input logic pop_at_hs,
                         output logic [31:0] addr, output int rise_c, output int hs_c);
        int n;
        n = 0;
        while (!M_AXI_ARVALID && n < 200) begin
            tick(1);
            n++;
        end
        check("ar_timeout", M_AXI_ARVALID, 1);
        addr   = M_AXI_ARADDR;
        rise_c = cyc;
        hs_c   = cyc;
        if (!M_AXI_ARVALID) return;
        for (int i = 0; i < ar_stall; i++) begin
            tick(1);
            check("ar_hold_valid", M_AXI_ARVALID, 1);
            check("ar_hold_addr", M_AXI_ARADDR, addr);
        end
        M_AXI_ARREADY = 1'b1;
        tick(1);
        M_AXI_ARREADY = 1'b0;
        check("ar_drop_after_hs", M_AXI_ARVALID, 0);
        check("rready_after_ar", M_AXI_RREADY, 1);
        tick(r_lat);
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = data;
        M_AXI_RRESP  = resp;
        byte_ready   = pop_at_hs;
        tick(1);
        hs_c = cyc;
        M_AXI_RVALID = 1'b0;
        M_AXI_RRESP  = 2'b00;
        M_AXI_RDATA  = $urandom;
        byte_ready   = 1'b0;
        check("rready_after_r", M_AXI_RREADY, 0);
    endtask

    task automatic stat_empty(input int st, output int rise_c, output int hs_c);
        logic [31:0] a;
        serve($urandom & 32'hFFFF_FFFE, st, int'($urandom_range(3, 0)), 2'b00, 1'b0, a, rise_c, hs_c);
        check("stat_addr", a, STAT);
    endtask

    task automatic rx_byte(input logic [7:0] b, output int hs_rx);
        logic [31:0] a;
        int r, h, r2;
        serve(($urandom & 32'hFFFF_FFFE) | 32'h1, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
              2'b00, 1'b0, a, r, h);
        check("stat_addr", a, STAT);
        serve({$urandom_range(255, 0), 24'h0} | {24'h0, b}, int'($urandom_range(2, 0)),
              int'($urandom_range(2, 0)), 2'b00, 1'b0, a, r2, hs_rx);
        check("rx_addr", a, RX);
        check("rx_ar_same_edge", r2 - h, 0);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        check("push_count", fifo_count, exp_q.size());
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        check("pop_valid", byte_valid, 1);
        check(tag, byte_data, e);
        byte_ready = 1'b1;
        tick(1);
        byte_ready = 1'b0;
    endtask

    initial begin
        int r, h, ph, hrx, seen, n;
        logic [31:0] a;
        logic [7:0] b;

        RSTN = 1'b0;
        tick(3);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_araddr", M_AXI_ARADDR, 0);
        check("rst_arprot", M_AXI_ARPROT, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_data", byte_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
`ifdef UART_POLL_RESP_CHK_EN
        check("rst_resp_err", resp_err, 0);
`endif
        RSTN = 1'b1;
        tick(4);
        check("disabled_no_ar", M_AXI_ARVALID, 0);

        // empty polls spaced by the gap counter
        enable = 1'b1;
        stat_empty(0, r, ph);
        for (int i = 0; i < 2; i++) begin
            stat_empty(int'($urandom_range(2, 0)), r, h);
            check("poll_gap", r - ph, GAP + 1);
            ph = h;
        end
        check("empty_poll_count", fifo_count, 0);

        // first byte
        rx_byte(8'hA5, hrx);
        check("first_valid", byte_valid, 1);
        check("first_data", byte_data, 8'hA5);
        stat_empty(0, r, h);
        check("repoll_after_rx", r - hrx, 1);
        pop_one("pop_a5");

        // long ARREADY stall
        stat_empty(10, r, h);
        check("busy_after_stat", busy, 0);

        // fill to capacity with consumer stalled
        for (int i = 1; i <= DEPTH; i++) rx_byte(8'(i), hrx);
        check("full_count", fifo_count, DEPTH);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (M_AXI_ARVALID) seen++;
        end
        check("no_ar_when_full", seen, 0);
        check("busy_when_full", busy, 0);
        while (exp_q.size() > 0) pop_one("drain_order");
        check("overflow_after_fill", overflow, 0);
        stat_empty(0, r, h);

        // push and pop on the same edge at occupancy 3
        for (int i = 0; i < 3; i++) rx_byte(8'($urandom), hrx);
        check("pre_simul_count", fifo_count, 3);
        serve(32'h1, 0, 1, 2'b00, 1'b0, a, r, h);
        check("stat_addr", a, STAT);
        b = 8'($urandom);
        check("head_before_simul", byte_data, exp_q[0]);
        serve({24'h0, b}, 0, 1, 2'b00, 1'b1, a, r, h);
        check("rx_addr", a, RX);
        void'(exp_q.pop_front());
        exp_q.push_back(b);
        check("simul_count", fifo_count, 3);
        while (exp_q.size() > 0) pop_one("simul_order");

        // randomized mix of empty polls, bytes and pops
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(1, 0) == 1) rx_byte(8'($urandom), hrx);
            else stat_empty(int'($urandom_range(3, 0)), r, h);
            if (exp_q.size() > 0 && (exp_q.size() >= 6 || $urandom_range(3, 0) == 0)) pop_one("rand_order");
        end
        while (exp_q.size() > 0) pop_one("rand_drain");

        // enable dropped while a poll is outstanding
        n = 0;
        while (!M_AXI_ARVALID && n < 50) begin
            tick(1);
            n++;
        end
        enable = 1'b0;
        stat_empty(2, r, h);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (M_AXI_ARVALID) seen++;
        end
        check("no_ar_disabled", seen, 0);
        check("idle_disabled", busy, 0);
        enable = 1'b1;

        // reset during RX address phase
        rx_byte(8'($urandom), hrx);
        serve(32'h1, 0, 0, 2'b00, 1'b0, a, r, h);
        check("stat_addr", a, STAT);
        check("rx_ar_pending", M_AXI_ARVALID, 1);
        check("rx_ar_addr", M_AXI_ARADDR, RX);
        RSTN = 1'b0;
        tick(1);
        RSTN = 1'b1;
        exp_q.delete();
        check("midrst_arvalid", M_AXI_ARVALID, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_valid", byte_valid, 0);
        stat_empty(0, r, h);

`ifdef UART_POLL_RESP_CHK_EN
        serve(32'h1, 0, 0, 2'b10, 1'b0, a, r, ph);
        check("err_stat_addr", a, STAT);
        check("err_stat_resp_err", resp_err, 1);
        stat_empty(0, r, h);
        check("err_stat_as_empty_gap", r - ph, GAP + 1);
        serve(32'h1, 0, 0, 2'b00, 1'b0, a, r, h);
        serve(32'h5A, 0, 1, 2'b10, 1'b0, a, r, h);
        check("err_rx_addr", a, RX);
        check("err_rx_no_push", fifo_count, 0);
        check("err_rx_resp_err", resp_err, 1);
`endif

        check("final_overflow", overflow, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_poller.md
Name: uart_rx_poller

Overview:
- AXI4-Lite read-only master that sequences the AXI UART Lite slave.
- Polls the STAT register (0x8) and, when bit0 (RX valid) is set, reads RX FIFO (0x0).
- Pushes received bytes into a local FIFO, presented as a valid/ready byte stream.
- Consumers are the bootloader and the core's MMIO load path. This removes per-consumer AXI sequencing.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of two, 2..256.
- POLL_GAP, 4, idle CLK cycles between an empty STAT poll and the next poll; 0 means back-to-back.
- STAT_ADDR, 32'h8, UART status register address.
- RX_ADDR, 32'h0, UART RX FIFO register address.

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, synchronous, active-low
- enable  in  1  polling allowed; when low, no new AR is issued
- M_AXI_ARADDR  out  32  read address
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARREADY  in  1  read address ready
- M_AXI_RDATA  in  32  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  read data ready
- byte_data  out  8  FIFO head byte
- byte_valid  out  1  FIFO non-empty
- byte_ready  in  1  consumer pops when byte_valid & byte_ready
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky; set if a byte is received while the FIFO is full
- busy  out  1  state != S_IDLE

Behaviour:
- Reset values (RSTN low at posedge): all outputs 0, state S_IDLE, FIFO empty, gap counter 0, ARADDR 0.
- Reset mid-transaction abandons it immediately. Slave-side recovery is the system's concern, since the UART is reset by the same RSTN.
- States:
  - S_IDLE: transition when enable=1, gap counter == 0 and fifo_count < FIFO_DEPTH. Action: ARADDR <= STAT_ADDR, ARVALID <= 1, go to S_STAT_AR.
  - S_STAT_AR: hold ARVALID/ARADDR stable until ARREADY. On ARVALID & ARREADY: ARVALID <= 0, RREADY <= 1, go to S_STAT_R.
  - S_STAT_R: on RVALID & RREADY, RREADY <= 0.
    - If RDATA[0]=1: ARADDR <= RX_ADDR, ARVALID <= 1, go to S_RX_AR.
    - Else: gap counter <= POLL_GAP, go to S_IDLE.
  - S_RX_AR: same handshake as S_STAT_AR, then go to S_RX_R.
  - S_RX_R: on RVALID & RREADY, RREADY <= 0 and push RDATA[7:0]; go to S_IDLE with gap counter 0, so the next STAT poll issues immediately.
- The gap counter decrements by 1 per cycle in S_IDLE while nonzero.
- Only one outstanding transaction at a time. ARVALID is never deasserted before ARREADY.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits; pointers wrap modulo FIFO_DEPTH.
  - byte_data is the registered head entry (byte_data = mem[rptr]). It is valid the same cycle fifo_count > 0; first-word latency is 1 cycle after the push.
  - Push and pop in the same cycle: fifo_count unchanged, both pointers advance.
  - Pop on empty is ignored.
- Full handling:
  - S_IDLE never starts a poll while full. A byte is therefore only dropped if the FIFO filled between STAT issue and RX push, which cannot happen with a single writer.
  - If a push occurs on full, the byte is dropped and overflow is set.
  - overflow clears only on reset.
- enable falling mid-transaction: the current transaction completes, then the block stays in S_IDLE.
- busy is combinational from state.

Optional Feature:
- Macro: UART_POLL_RESP_CHK_EN
- Defined:
  - Any R beat with RRESP != 2'b00 is treated as an error.
  - In S_STAT_R it counts as "no data". In S_RX_R the byte is not pushed.
  - Sticky output port resp_err (1 bit, reset 0) is set on any such beat.
  - The port exists only when the macro is defined.
- Undefined: RRESP is ignored and resp_err is absent.

Test Plan:
- STAT returns 0x0 three times, POLL_GAP=4 -> three STAT reads, ARVALID edges ≥5 cycles apart, no RX read, fifo_count=0.
- STAT=0x1 then RX RDATA=0x000000A5 -> ARADDR sequence 0x8,0x0; byte_valid=1, byte_data=0xA5 one cycle after the R handshake; fifo_count=1.
- ARREADY held low 10 cycles -> ARVALID and ARADDR stay stable all 10 cycles; exactly one handshake.
- FIFO_DEPTH=8, byte_ready=0, 8 bytes 0x01..0x08 -> fifo_count=8, no further AR issued. Then byte_ready=1 -> bytes pop in order 0x01..0x08, polling resumes, overflow=0.
- Pop and push in the same cycle with fifo_count=3 -> fifo_count stays 3, byte order preserved.
- With UART_POLL_RESP_CHK_EN defined: RX beat RRESP=2'b10 -> no push, resp_err=1. RSTN low mid-S_RX_AR -> ARVALID=0, state S_IDLE, FIFO empty next cycle.
